// File: rtl/opc5_uart_pkg.sv
// Shared definitions for the OPC5 memory-mapped UART: register offsets,
// status bit positions, serial FSM states and the status word packer.
package opc5_uart_pkg;

  localparam logic [15:0] OFS_DATA   = 16'd0;
  localparam logic [15:0] OFS_STATUS = 16'd1;

  localparam int SB_FIFO_FULL    = 0;
  localparam int SB_FIFO_EMPTY   = 1;
  localparam int SB_TX_BUSY      = 2;
  localparam int SB_RX_VALID     = 3;
  localparam int SB_RX_OVERRUN   = 4;
  localparam int SB_TX_OVERFLOW  = 5;
  localparam int SB_RX_FRAME_ERR = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  function automatic logic [15:0] pack_status(input logic [7:0] cnt, input logic [6:0] flags);
    return {cnt, 1'b0, flags};
  endfunction

endpackage

// File: rtl/opc5_uart_if.sv
// CPU data-bus view of the OPC5 UART: the CPU is master, the UART is slave.
interface opc5_uart_if;
  logic [15:0] address;
  logic [15:0] dataout;
  logic        rnw;
  logic        hit;
  logic [15:0] rdata;

  modport master (output address, dataout, rnw, input hit, rdata);
  modport slave  (input address, dataout, rnw, output hit, rdata);
endinterface

// File: rtl/opc5_uart_fifo.sv
// Single-clock byte FIFO for the UART transmit path. A push while full is
// dropped even when a pop happens on the same edge.
module opc5_uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {(AW + 1){1'b0}});
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // storage array, written on accepted push only
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // pointers and occupancy; pointers wrap naturally as DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/opc5_uart.sv
// OPC5 memory-mapped UART: DATA/STATUS registers, TX FIFO and serializer.
// The receiver is only built when OPC5_UART_RX_EN is defined.
module opc5_uart
  import opc5_uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'hFE00,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          TX_DEPTH     = 8
) (
  input  logic            clk,
  input  logic            reset_b,
  opc5_uart_if.slave      bus,
  output logic            txd,
  input  logic            rxd
);

  localparam int          CW          = $clog2(TX_DEPTH) + 1;
  localparam logic [15:0] BIT_END     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] ADDR_DATA   = BASE_ADDR + OFS_DATA;
  localparam logic [15:0] ADDR_STATUS = BASE_ADDR + OFS_STATUS;

  logic          sel_data_s, sel_stat_s, wr_data_s, wr_stat_s;
  logic          fifo_full_s, fifo_empty_s, tx_pop_s, tx_end_s;
  logic [7:0]    fifo_data_s;
  logic [CW-1:0] fifo_count_s;
  uart_state_e   tx_state_r;
  logic [15:0]   tx_tmr_r;
  logic [2:0]    tx_idx_r;
  logic [7:0]    tx_shift_r;
  logic          txd_r;
  logic          tx_overflow_r;
  logic [7:0]    rx_data_s;
  logic          rx_valid_s, rx_overrun_s, rx_frame_err_s;
  logic [6:0]    flags_s;
  logic [15:0]   rdata_s;
  logic          unused_s;

  assign sel_data_s = (bus.address == ADDR_DATA);
  assign sel_stat_s = (bus.address == ADDR_STATUS);
  assign wr_data_s  = sel_data_s & ~bus.rnw;
  assign wr_stat_s  = sel_stat_s & ~bus.rnw;
  assign bus.hit    = sel_data_s | sel_stat_s;
  assign bus.rdata  = rdata_s;
  assign txd        = txd_r;

  assign tx_end_s = (tx_tmr_r == BIT_END);
  assign tx_pop_s = ~fifo_empty_s &
                    ((tx_state_r == S_IDLE) | ((tx_state_r == S_STOP) & tx_end_s));

  opc5_uart_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_b   (reset_b),
    .push      (wr_data_s),
    .push_data (bus.dataout[7:0]),
    .pop       (tx_pop_s),
    .pop_data  (fifo_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // transmit serializer; the STOP-end edge reloads directly for gapless frames
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      tx_state_r <= S_IDLE;
      tx_tmr_r   <= 16'd0;
      tx_idx_r   <= 3'd0;
      tx_shift_r <= 8'd0;
      txd_r      <= 1'b1;
    end else begin
      case (tx_state_r)
        S_IDLE: begin
          if (tx_pop_s) begin
            tx_state_r <= S_START;
            tx_tmr_r   <= 16'd0;
            tx_shift_r <= fifo_data_s;
            txd_r      <= 1'b0;
          end
        end
        S_START: begin
          if (tx_end_s) begin
            tx_state_r <= S_DATA;
            tx_tmr_r   <= 16'd0;
            tx_idx_r   <= 3'd0;
            txd_r      <= tx_shift_r[0];
          end else begin
            tx_tmr_r <= tx_tmr_r + 16'd1;
          end
        end
        S_DATA: begin
          if (tx_end_s) begin
            tx_tmr_r <= 16'd0;
            if (tx_idx_r == 3'd7) begin
              tx_state_r <= S_STOP;
              txd_r      <= 1'b1;
            end else begin
              tx_idx_r   <= tx_idx_r + 3'd1;
              tx_shift_r <= {1'b0, tx_shift_r[7:1]};
              txd_r      <= tx_shift_r[1];
            end
          end else begin
            tx_tmr_r <= tx_tmr_r + 16'd1;
          end
        end
        S_STOP: begin
          if (tx_end_s) begin
            tx_tmr_r <= 16'd0;
            if (tx_pop_s) begin
              tx_state_r <= S_START;
              tx_shift_r <= fifo_data_s;
              txd_r      <= 1'b0;
            end else begin
              tx_state_r <= S_IDLE;
            end
          end else begin
            tx_tmr_r <= tx_tmr_r + 16'd1;
          end
        end
        default: begin
          tx_state_r <= S_IDLE;
          txd_r      <= 1'b1;
        end
      endcase
    end
  end

  // sticky TX overflow, judged on pre-edge fullness; set beats clear
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      tx_overflow_r <= 1'b0;
    end else if (wr_data_s & fifo_full_s) begin
      tx_overflow_r <= 1'b1;
    end else if (wr_stat_s & bus.dataout[SB_TX_OVERFLOW]) begin
      tx_overflow_r <= 1'b0;
    end else begin
      tx_overflow_r <= tx_overflow_r;
    end
  end

`ifdef OPC5_UART_RX_EN
  localparam logic [15:0] RX_HALF = 16'(CLKS_PER_BIT / 2);

  logic [2:0]  rx_sync_r;
  uart_state_e rx_state_r;
  logic [15:0] rx_tmr_r;
  logic [2:0]  rx_idx_r;
  logic [7:0]  rx_shift_r;
  logic [7:0]  rx_data_r;
  logic        rx_valid_r, rx_overrun_r, rx_frame_err_r;
  logic        rx_bit_s, rx_fall_s, rx_stop_smp_s, rx_ok_s, rx_bad_s;

  assign rx_bit_s      = rx_sync_r[1];
  assign rx_fall_s     = rx_sync_r[2] & ~rx_sync_r[1];
  assign rx_stop_smp_s = (rx_state_r == S_STOP) & (rx_tmr_r == BIT_END);
  assign rx_ok_s       = rx_stop_smp_s & rx_bit_s;
  assign rx_bad_s      = rx_stop_smp_s & ~rx_bit_s;

  // two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rx_sync_r <= 3'b111;
    end else begin
      rx_sync_r <= {rx_sync_r[1:0], rxd};
    end
  end

  // receive deserializer; START entry counts the detection clock as 1
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rx_state_r <= S_IDLE;
      rx_tmr_r   <= 16'd0;
      rx_idx_r   <= 3'd0;
      rx_shift_r <= 8'd0;
    end else begin
      case (rx_state_r)
        S_IDLE: begin
          if (rx_fall_s) begin
            rx_state_r <= S_START;
            rx_tmr_r   <= 16'd1;
          end
        end
        S_START: begin
          if (rx_tmr_r == RX_HALF) begin
            rx_tmr_r   <= 16'd0;
            rx_idx_r   <= 3'd0;
            rx_state_r <= rx_bit_s ? S_IDLE : S_DATA;
          end else begin
            rx_tmr_r <= rx_tmr_r + 16'd1;
          end
        end
        S_DATA: begin
          if (rx_tmr_r == BIT_END) begin
            rx_tmr_r   <= 16'd0;
            rx_shift_r <= {rx_bit_s, rx_shift_r[7:1]};
            rx_idx_r   <= rx_idx_r + 3'd1;
            if (rx_idx_r == 3'd7) begin
              rx_state_r <= S_STOP;
            end
          end else begin
            rx_tmr_r <= rx_tmr_r + 16'd1;
          end
        end
        S_STOP: begin
          if (rx_tmr_r == BIT_END) begin
            rx_tmr_r   <= 16'd0;
            rx_state_r <= S_IDLE;
          end else begin
            rx_tmr_r <= rx_tmr_r + 16'd1;
          end
        end
        default: rx_state_r <= S_IDLE;
      endcase
    end
  end

  // received byte and sticky RX flags; set beats write-1-to-clear
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rx_data_r      <= 8'd0;
      rx_valid_r     <= 1'b0;
      rx_overrun_r   <= 1'b0;
      rx_frame_err_r <= 1'b0;
    end else begin
      rx_data_r <= rx_ok_s ? rx_shift_r : rx_data_r;
      rx_valid_r <= rx_ok_s ? 1'b1 :
                    ((wr_stat_s & bus.dataout[SB_RX_VALID]) ? 1'b0 : rx_valid_r);
      rx_overrun_r <= (rx_ok_s & rx_valid_r) ? 1'b1 :
                      ((wr_stat_s & bus.dataout[SB_RX_OVERRUN]) ? 1'b0 : rx_overrun_r);
      rx_frame_err_r <= rx_bad_s ? 1'b1 :
                        ((wr_stat_s & bus.dataout[SB_RX_FRAME_ERR]) ? 1'b0 : rx_frame_err_r);
    end
  end

  assign rx_data_s      = rx_data_r;
  assign rx_valid_s     = rx_valid_r;
  assign rx_overrun_s   = rx_overrun_r;
  assign rx_frame_err_s = rx_frame_err_r;
  assign unused_s       = ^bus.dataout[15:8];
`else
  assign rx_data_s      = 8'h00;
  assign rx_valid_s     = 1'b0;
  assign rx_overrun_s   = 1'b0;
  assign rx_frame_err_s = 1'b0;
  assign unused_s       = ^{bus.dataout[15:8], rxd};
`endif

  // status flags and read mux; bus reads have no side effects
  always_comb begin
    flags_s                  = 7'd0;
    flags_s[SB_FIFO_FULL]    = fifo_full_s;
    flags_s[SB_FIFO_EMPTY]   = fifo_empty_s;
    flags_s[SB_TX_BUSY]      = (tx_state_r != S_IDLE);
    flags_s[SB_RX_VALID]     = rx_valid_s;
    flags_s[SB_RX_OVERRUN]   = rx_overrun_s;
    flags_s[SB_TX_OVERFLOW]  = tx_overflow_r;
    flags_s[SB_RX_FRAME_ERR] = rx_frame_err_s;
    rdata_s                  = 16'h0000;
    if (sel_data_s) begin
      rdata_s = {8'h00, rx_data_s};
    end else if (sel_stat_s) begin
      rdata_s = pack_status(8'(fifo_count_s), flags_s);
    end else begin
      rdata_s = 16'h0000;
    end
  end

endmodule

// File: tb/tb_opc5_uart.sv
// Directed bench for opc5_uart (CLKS_PER_BIT=4, TX_DEPTH=4, BASE=FE00);
// the RX section is selected by OPC5_UART_RX_EN.
`timescale 1ns/1ps
module tb_opc5_uart;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [15:0] BASE  = 16'hFE00;
  localparam logic [15:0] STAT  = 16'hFE01;

  typedef struct packed {
    logic        rnw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        hit;
    logic [15:0] rdata;
  } vec_t;

  logic clk     = 1'b0;
  logic reset_b = 1'b0;
  logic rxd     = 1'b1;
  logic txd;
  int   n_vec   = 0;
  int   n_bad   = 0;
  vec_t tbl [10];
  logic [7:0] ob [6];

  always #5 clk = ~clk;

  opc5_uart_if bus ();

  opc5_uart #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .TX_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus),
    .txd     (txd),
    .rxd     (rxd)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rnw_v, input logic [15:0] addr, input logic [15:0] wd);
    bus.rnw     = rnw_v;
    bus.address = addr;
    bus.dataout = wd;
  endtask

  // checks txd over frame clocks first_j..last_j; entered at the negedge after pop+first_j
  task automatic watch_frame(input logic [7:0] b, input int first_j, input int last_j);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int j = first_j; j <= last_j; j++) begin
      #1;
      check("txd_bit", {15'd0, txd}, {15'd0, fr[j / CPB]});
      if (j == 20) check("tx_busy", {15'd0, bus.rdata[2]}, 16'd1);
      @(negedge clk);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd = fr[k];
      repeat (CPB) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic read_chk(input string name, input logic [15:0] addr, input logic [15:0] exp);
    drive(1'b1, addr, 16'h0000);
    #1;
    check(name, bus.rdata, exp);
  endtask

  initial begin
    tbl[0] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    tbl[1] = '{1'b1, STAT,     16'h0000, 1'b1, 16'h0002};
    tbl[2] = '{1'b1, BASE,     16'h0000, 1'b1, 16'h0000};
    tbl[3] = '{1'b1, 16'hFE02, 16'h0000, 1'b0, 16'h0000};
    tbl[4] = '{1'b1, 16'hFDFF, 16'h0000, 1'b0, 16'h0000};
    tbl[5] = '{1'b0, STAT,     16'hFFFF, 1'b1, 16'h0002};
    tbl[6] = '{1'b1, STAT,     16'h0000, 1'b1, 16'h0002};
    tbl[7] = '{1'b0, 16'hFE02, 16'h1234, 1'b0, 16'h0000};
    tbl[8] = '{1'b1, STAT,     16'h0000, 1'b1, 16'h0002};
    tbl[9] = '{1'b1, 16'hFFFF, 16'h0000, 1'b0, 16'h0000};
    ob = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    drive(1'b1, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    #1 check("txd_in_reset", {15'd0, txd}, 16'd1);
    reset_b = 1'b1;
    @(negedge clk);

    // register map after reset
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].rnw, tbl[i].addr, tbl[i].wdata);
      #1;
      check("tbl_hit", {15'd0, bus.hit}, {15'd0, tbl[i].hit});
      check("tbl_rdata", bus.rdata, tbl[i].rdata);
      check("tbl_txd", {15'd0, txd}, 16'd1);
      @(negedge clk);
    end

    // single frame, upper write byte ignored
    drive(1'b0, BASE, 16'h1255);
    @(negedge clk);
    read_chk("stat_queued", STAT, 16'h0100);
    @(negedge clk);
    #1 check("stat_sending", bus.rdata, 16'h0006);
    watch_frame(8'h55, 0, 39);
    #1 check("txd_idle", {15'd0, txd}, 16'd1);
    check("stat_idle", bus.rdata, 16'h0002);

    // six back-to-back writes into a 4-deep FIFO
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, BASE, {8'hC3, ob[i]});
      @(negedge clk);
    end
    read_chk("stat_overflow", STAT, 16'h0425);
    watch_frame(ob[0], 4, 39);
    for (int i = 1; i < 5; i++) watch_frame(ob[i], 0, 39);
    read_chk("stat_ovf_idle", STAT, 16'h0022);
    drive(1'b0, STAT, 16'h0058);
    @(negedge clk);
    read_chk("ovf_kept", STAT, 16'h0022);
    drive(1'b0, STAT, 16'h0020);
    @(negedge clk);
    read_chk("ovf_cleared", STAT, 16'h0002);

    // push and pop on the STOP-end edge
    drive(1'b0, BASE, 16'h000F);
    @(negedge clk);
    drive(1'b1, STAT, 16'h0000);
    @(negedge clk);
    watch_frame(8'h0F, 0, 9);
    drive(1'b0, BASE, 16'h00C3);
    @(negedge clk);
    read_chk("stat_one_queued", STAT, 16'h0104);
    watch_frame(8'h0F, 11, 38);
    drive(1'b0, BASE, 16'h0081);
    @(negedge clk);
    read_chk("stat_pushpop", STAT, 16'h0104);
    check("no_gap_txd", {15'd0, txd}, 16'd0);
    watch_frame(8'hC3, 0, 39);
    watch_frame(8'h81, 0, 39);
    read_chk("stat_after_chain", STAT, 16'h0002);

    // asynchronous reset during the DATA phase
    drive(1'b0, BASE, 16'h0000);
    @(negedge clk);
    drive(1'b0, BASE, 16'h005B);
    @(negedge clk);
    drive(1'b1, STAT, 16'h0000);
    repeat (10) @(negedge clk);
    #1 check("txd_mid_frame", {15'd0, txd}, 16'd0);
    check("stat_mid_frame", bus.rdata, 16'h0104);
    #1 reset_b = 1'b0;
    #1 check("txd_async_reset", {15'd0, txd}, 16'd1);
    check("stat_async_reset", bus.rdata, 16'h0002);
    @(negedge clk);
    reset_b = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("txd_after_reset", {15'd0, txd}, 16'd1);
    check("stat_after_reset", bus.rdata, 16'h0002);

    // one-clock glitch on rxd
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (12) @(negedge clk);
    read_chk("stat_glitch", STAT, 16'h0002);

`ifdef OPC5_UART_RX_EN
    send_rx(8'hA5, 1'b1);
    read_chk("rx_data_a5", BASE, 16'h00A5);
    read_chk("rx_stat_valid", STAT, 16'h000A);
    send_rx(8'h3C, 1'b1);
    read_chk("rx_data_3c", BASE, 16'h003C);
    read_chk("rx_stat_overrun", STAT, 16'h001A);
    send_rx(8'h77, 1'b0);
    read_chk("rx_data_kept", BASE, 16'h003C);
    read_chk("rx_stat_frame", STAT, 16'h005A);
    drive(1'b0, STAT, 16'h0058);
    @(negedge clk);
    read_chk("rx_stat_cleared", STAT, 16'h0002);
    read_chk("rx_data_after_clr", BASE, 16'h003C);
`else
    send_rx(8'hA5, 1'b1);
    read_chk("norx_data", BASE, 16'h0000);
    read_chk("norx_stat", STAT, 16'h0002);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/opc5_uart.md
Name: opc5_uart

Overview:
- Memory-mapped UART peripheral on the OPC5 CPU data bus, downstream of the CPU's address, dataout and rnw outputs.
- Returns read data on a 16-bit bus that the top level muxes into CPU datain.
- Contains a TX FIFO, a TX serializer and an optional RX deserializer.
- Read data is combinational from registered state, because the CPU samples datain in the same cycle it drives address.

Parameters:
BASE_ADDR, 16'hFE00, word address of the DATA register; STATUS is at BASE_ADDR+1
CLKS_PER_BIT, 434, clocks per serial bit; legal range 4..65535
TX_DEPTH, 8, TX FIFO entries; power of two, 2..128

Ports:
clk  input  1  system clock; all state updates on rising edge
reset_b  input  1  asynchronous active-low reset
address  input  16  CPU address bus
dataout  input  16  CPU write data
rnw  input  1  CPU read-not-write; 0 = write this cycle
hit  output  1  combinational; high when address is BASE_ADDR or BASE_ADDR+1
rdata  output  16  combinational read data; 16'h0000 when hit is low
txd  output  1  serial transmit, idle high
rxd  input  1  serial receive, asynchronous to clk

Behaviour:
- Reset: FIFO empty; TX FSM IDLE; txd=1; all status flags 0; rx_data=0; RX FSM IDLE.
- Reset takes effect immediately, including mid-frame: txd returns to 1 asynchronously and any partial RX byte is discarded.
- Write DATA (rnw=0, address=BASE_ADDR at a rising edge):
  - Pushes dataout[7:0]; dataout[15:8] is ignored.
  - If the FIFO is full (evaluated on pre-edge count), the byte is dropped and sticky tx_overflow is set, even if a pop happens on the same edge.
- Write STATUS: write-1-to-clear. bit3 clears rx_valid, bit4 clears rx_overrun, bit5 clears tx_overflow, bit6 clears rx_frame_err. All other bits are ignored.
- Read DATA: {8'h00, rx_data}. No read side effects, since address may sit on the bus for instruction fetch.
- Read STATUS: [0] fifo_full, [1] fifo_empty, [2] tx_busy (FSM not IDLE), [3] rx_valid, [4] rx_overrun, [5] tx_overflow, [6] rx_frame_err, [7] 0, [15:8] FIFO count.
- Push and pop on the same edge: both occur, count unchanged.
- Set and W1C clear of the same flag on the same edge: set wins.
- TX FSM IDLE -> START -> DATA -> STOP -> IDLE:
  - In IDLE with FIFO non-empty: pop at the edge and load the shifter; txd=0 from that edge.
  - Each state lasts CLKS_PER_BIT clocks, counted by a bit-timer.
  - DATA sends 8 bits LSB first. STOP drives 1.
  - At the end of STOP, go to IDLE. If the FIFO is non-empty at that edge, pop directly and go to START with no idle gap.
- TX latency: DATA write at edge N -> pop at edge N+1 -> txd low after N+1. Frame length is 10*CLKS_PER_BIT clocks.
- RX input: rxd passes through a 2-flop synchronizer.
- RX FSM IDLE -> START -> DATA -> STOP:
  - IDLE -> START on synchronized falling edge.
  - At CLKS_PER_BIT/2 (integer division), sample. If high, treat as a glitch and return to IDLE with no flag set.
  - Otherwise sample 8 data bits at CLKS_PER_BIT spacing, LSB first.
  - Sample the stop bit. If 1: rx_data <= byte, rx_valid <= 1; if rx_valid was already set, also set rx_overrun (new byte overwrites). If 0: discard byte, set rx_frame_err.
  - Return to IDLE.

Optional Feature:
OPC5_UART_RX_EN:
- Defined: RX synchronizer, RX FSM and RX flags are present as described above.
- Undefined: rxd is unused; status bits 3, 4 and 6 and DATA read all return 0; RX logic is not instantiated.

Decomposition:
- Package opc5_uart_pkg holds:
  - register offsets (OFS_DATA=0, OFS_STATUS=1) and status bit indices;
  - TX/RX state enum (IDLE, START, DATA, STOP).
- Sub-module opc5_uart_fifo: synchronous single-clock FIFO with push, pop, full, empty and count; depth parameterised; same clk/reset_b.

Test Plan (CLKS_PER_BIT=4, TX_DEPTH=4, BASE_ADDR=16'hFE00):
- Reset: release reset_b -> txd=1, STATUS read at FE01 = 16'h0002, hit=0 at address 16'h0000 with rdata=0.
- Single TX: write 16'h1255 to FE00 -> txd low from next edge for 4 clks, then bits 1,0,1,0,1,0,1,0 at 4 clks each, stop 1; STATUS[2]=1 during frame.
- Overflow: write 6 bytes back-to-back -> first pops immediately, next 4 fill FIFO, 6th dropped; STATUS = 16'h0425; all 5 accepted bytes appear on txd with no gaps; write 16'h0020 to FE01 clears bit5.
- Simultaneous push/pop: write during the STOP-end edge with FIFO count 1 -> count stays 1, next frame starts without an idle cycle.
- RX (feature on): drive frame for 8'hA5 on rxd -> DATA reads 16'h00A5, STATUS[3]=1; send 8'h3C without clearing -> DATA 16'h003C, STATUS[4]=1; stop bit 0 -> STATUS[6]=1, DATA unchanged.
- Reset mid-frame: assert reset_b low during the TX DATA state -> txd=1 immediately, FIFO count 0; 1-clock low glitch on rxd -> no rx_valid.
